// File: rtl/rr_pkt_mux.sv
// Packet-level mux behind a round-robin arbiter: follows the arbiter grant
// until a packet begins, holds that source to its last beat, then acks.
module rr_pkt_mux #(
  parameter int unsigned W      = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [W-1:0]           i_gnt,
  output logic                   o_ack,
  input  logic [W-1:0]           i_vld,
  input  logic [W*DATA_W-1:0]    i_data,
  input  logic [W-1:0]           i_last,
  output logic [W-1:0]           o_rdy,
  output logic                   o_vld,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_last,
  output logic [$clog2(W)-1:0]   o_src,
  input  logic                   i_rdy
);

  localparam int unsigned IdxW = $clog2(W);

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   lock_q, lock_d;
  logic [IdxW-1:0]   gnt_idx;
  logic [IdxW-1:0]   cur_src;
  logic              src_valid;
  logic              can_acc;
  logic              acc;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IdxW-1:0]   src_q, src_d;

  // OR-encoder: exact for a one-hot grant, zero for an empty one.
  always_comb begin
    gnt_idx = '0;
    for (int unsigned k = 0; k < W; k++) begin
      if (i_gnt[k]) begin
        gnt_idx = gnt_idx | IdxW'(k);
      end
    end
  end

  always_comb begin
    cur_src   = (state_q == StLocked) ? lock_q : gnt_idx;
    src_valid = (state_q == StLocked) || (|i_gnt);
    can_acc   = !vld_q || i_rdy;
    o_rdy     = '0;
    sel_data  = '0;
    sel_last  = 1'b0;
    for (int unsigned k = 0; k < W; k++) begin
      if (IdxW'(k) == cur_src) begin
        sel_data = i_data[k*DATA_W +: DATA_W];
        sel_last = i_last[k];
        o_rdy[k] = can_acc && src_valid && !arst;
      end
    end
    acc   = |(i_vld & o_rdy);
    o_ack = acc && sel_last;
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    unique case (state_q)
      StIdle: begin
        if (acc && !sel_last) begin
          state_d = StLocked;
          lock_d  = cur_src;
        end
      end
      StLocked: begin
        if (acc && sel_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A new beat takes priority over retiring, so back-to-back keeps o_vld high.
  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    data_d = data_q;
    src_d  = src_q;
    if (acc) begin
      vld_d  = 1'b1;
      last_d = sel_last;
      data_d = sel_data;
      src_d  = cur_src;
    end else if (i_rdy) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= StIdle;
      lock_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign o_vld  = vld_q;
  assign o_last = last_q;
  assign o_data = data_q;
  assign o_src  = src_q;

  gnt_onehot_a: assert property (@(posedge clk) disable iff (arst) $onehot0(i_gnt))
    else $error("rr_pkt_mux: grant is not one-hot");

endmodule

// File: tb/tb_rr_pkt_mux.sv
// Directed scenarios plus a randomized run against a queue-based packet model.
module tb_rr_pkt_mux;

  localparam int W      = 4;
  localparam int DATA_W = 32;
  localparam int IW     = 2;

  typedef struct packed {
    logic [IW-1:0]     src;
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic                clk  = 1'b0;
  logic                arst = 1'b1;
  logic [W-1:0]        gnt;
  logic                o_ack;
  logic [W-1:0]        vld;
  logic [W*DATA_W-1:0] data;
  logic [W-1:0]        last;
  logic [W-1:0]        o_rdy;
  logic                o_vld;
  logic [DATA_W-1:0]   o_data;
  logic                o_last;
  logic [IW-1:0]       o_src;
  logic                rdy;

  int checks = 0;
  int errors = 0;

  rr_pkt_mux #(.W(W), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .arst   (arst),
    .i_gnt  (gnt),
    .o_ack  (o_ack),
    .i_vld  (vld),
    .i_data (data),
    .i_last (last),
    .o_rdy  (o_rdy),
    .o_vld  (o_vld),
    .o_data (o_data),
    .o_last (o_last),
    .o_src  (o_src),
    .i_rdy  (rdy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    gnt  = '0;
    vld  = '0;
    last = '0;
    data = '0;
    rdy  = 1'b1;
  endtask

  task automatic set_beat(input int s, input logic [DATA_W-1:0] d, input logic l);
    vld[s]                   = 1'b1;
    last[s]                  = l;
    data[s*DATA_W +: DATA_W] = d;
  endtask

  task automatic drain();
    clear_in();
    #1;
    tick();
  endtask

  task automatic test_reset();
    clear_in();
    gnt = 4'b0010;
    set_beat(1, 32'h1234, 1'b1);
    tick();
    tick();
    checks++;
    if ({o_vld, o_src, o_last, o_data} !== 36'd0) begin
      errors++;
      $display("FAIL reset_out got %h want 0", {o_vld, o_src, o_last, o_data});
    end
    checks++;
    if ({o_rdy, o_ack} !== 5'd0) begin
      errors++;
      $display("FAIL reset_rdy_ack got %b want 00000", {o_rdy, o_ack});
    end
    clear_in();
    arst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    clear_in();
    gnt = 4'b0010;
    set_beat(1, 32'hA5, 1'b1);
    #1;
    checks++;
    if (o_rdy !== 4'b0010) begin
      errors++;
      $display("FAIL single_rdy got %b want 0010", o_rdy);
    end
    checks++;
    if (o_ack !== 1'b1) begin
      errors++;
      $display("FAIL single_ack got %b want 1", o_ack);
    end
    tick();
    clear_in();
    checks++;
    if ({o_vld, o_src, o_last, o_data} !== {1'b1, 2'd1, 1'b1, 32'hA5}) begin
      errors++;
      $display("FAIL single_out got %h want %h", {o_vld, o_src, o_last, o_data},
               {1'b1, 2'd1, 1'b1, 32'hA5});
    end
    #1;
    tick();
    checks++;
    if (o_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_retire got %b want 0", o_vld);
    end
  endtask

  task automatic test_lock();
    for (int b = 0; b < 3; b++) begin
      clear_in();
      gnt = (b == 0) ? 4'b0100 : 4'b0001;
      set_beat(0, 32'hDEAD, 1'b1);
      set_beat(2, 32'(b + 1), b == 2);
      #1;
      checks++;
      if (o_rdy !== 4'b0100) begin
        errors++;
        $display("FAIL lock_rdy beat %0d got %b want 0100", b, o_rdy);
      end
      checks++;
      if (o_ack !== (b == 2)) begin
        errors++;
        $display("FAIL lock_ack beat %0d got %b want %b", b, o_ack, b == 2);
      end
      tick();
      checks++;
      if ({o_vld, o_src, o_last, o_data} !== {1'b1, 2'd2, b == 2, 32'(b + 1)}) begin
        errors++;
        $display("FAIL lock_out beat %0d got %h want %h", b, {o_vld, o_src, o_last, o_data},
                 {1'b1, 2'd2, b == 2, 32'(b + 1)});
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int          srcs [3] = '{0, 0, 3};
    logic [31:0] dats [3] = '{32'h10, 32'h11, 32'h30};
    logic        lsts [3] = '{1'b0, 1'b1, 1'b1};
    int          acks = 0;
    for (int i = 0; i < 3; i++) begin
      clear_in();
      gnt = 4'b0001 << srcs[i];
      set_beat(srcs[i], dats[i], lsts[i]);
      #1;
      if (o_ack === 1'b1) acks++;
      checks++;
      if (o_rdy !== (4'b0001 << srcs[i])) begin
        errors++;
        $display("FAIL b2b_rdy beat %0d got %b want %b", i, o_rdy, 4'b0001 << srcs[i]);
      end
      tick();
      checks++;
      if ({o_vld, o_src, o_last, o_data} !== {1'b1, 2'(srcs[i]), lsts[i], dats[i]}) begin
        errors++;
        $display("FAIL b2b_out beat %0d got %h want %h", i, {o_vld, o_src, o_last, o_data},
                 {1'b1, 2'(srcs[i]), lsts[i], dats[i]});
      end
    end
    checks++;
    if (acks != 2) begin
      errors++;
      $display("FAIL b2b_acks got %0d want 2", acks);
    end
    drain();
  endtask

  task automatic test_downstream_stall();
    clear_in();
    gnt = 4'b0010;
    set_beat(1, 32'h20, 1'b0);
    #1;
    tick();
    for (int c = 0; c < 2; c++) begin
      clear_in();
      rdy = 1'b0;
      gnt = 4'b0010;
      set_beat(1, 32'h21, 1'b0);
      #1;
      checks++;
      if (o_rdy !== 4'b0000) begin
        errors++;
        $display("FAIL stall_rdy cycle %0d got %b want 0000", c, o_rdy);
      end
      tick();
      checks++;
      if ({o_vld, o_src, o_last, o_data} !== {1'b1, 2'd1, 1'b0, 32'h20}) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got %h want %h", c, {o_vld, o_src, o_last, o_data},
                 {1'b1, 2'd1, 1'b0, 32'h20});
      end
    end
    for (int b = 1; b < 3; b++) begin
      clear_in();
      set_beat(1, 32'(32'h20 + b), b == 2);
      #1;
      checks++;
      if ({o_rdy, o_ack} !== {4'b0010, b == 2}) begin
        errors++;
        $display("FAIL resume_rdy_ack beat %0d got %b want %b", b, {o_rdy, o_ack},
                 {4'b0010, b == 2});
      end
      tick();
      checks++;
      if ({o_vld, o_src, o_last, o_data} !== {1'b1, 2'd1, b == 2, 32'(32'h20 + b)}) begin
        errors++;
        $display("FAIL resume_out beat %0d got %h want %h", b, {o_vld, o_src, o_last, o_data},
                 {1'b1, 2'd1, b == 2, 32'(32'h20 + b)});
      end
    end
    drain();
  endtask

  task automatic test_source_stall();
    clear_in();
    gnt = 4'b1000;
    set_beat(3, 32'h40, 1'b0);
    #1;
    tick();
    for (int c = 0; c < 3; c++) begin
      clear_in();
      gnt = 4'b0001;
      set_beat(0, 32'h99, 1'b1);
      #1;
      checks++;
      if ({o_rdy, o_ack} !== {4'b1000, 1'b0}) begin
        errors++;
        $display("FAIL srcstall_rdy_ack cycle %0d got %b want 10000", c, {o_rdy, o_ack});
      end
      tick();
      checks++;
      if (o_vld !== 1'b0) begin
        errors++;
        $display("FAIL srcstall_vld cycle %0d got %b want 0", c, o_vld);
      end
    end
    clear_in();
    gnt = 4'b0001;
    set_beat(0, 32'h99, 1'b1);
    set_beat(3, 32'h41, 1'b1);
    #1;
    checks++;
    if ({o_rdy, o_ack} !== {4'b1000, 1'b1}) begin
      errors++;
      $display("FAIL srcstall_end got %b want 10001", {o_rdy, o_ack});
    end
    tick();
    checks++;
    if ({o_vld, o_src, o_last, o_data} !== {1'b1, 2'd3, 1'b1, 32'h41}) begin
      errors++;
      $display("FAIL srcstall_out got %h want %h", {o_vld, o_src, o_last, o_data},
               {1'b1, 2'd3, 1'b1, 32'h41});
    end
    drain();
  endtask

  task automatic test_reset_mid_packet();
    clear_in();
    gnt = 4'b0100;
    set_beat(2, 32'h50, 1'b0);
    #1;
    tick();
    checks++;
    if (o_vld !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got %b want 1", o_vld);
    end
    arst = 1'b1;
    #1;
    checks++;
    if ({o_vld, o_rdy, o_ack} !== 6'd0) begin
      errors++;
      $display("FAIL rstmid_async got %b want 000000", {o_vld, o_rdy, o_ack});
    end
    tick();
    clear_in();
    arst = 1'b0;
    gnt  = 4'b0001;
    set_beat(0, 32'h60, 1'b1);
    #1;
    checks++;
    if ({o_rdy, o_ack} !== {4'b0001, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_regrant got %b want 00011", {o_rdy, o_ack});
    end
    tick();
    checks++;
    if ({o_vld, o_src, o_last, o_data} !== {1'b1, 2'd0, 1'b1, 32'h60}) begin
      errors++;
      $display("FAIL rstmid_out got %h want %h", {o_vld, o_src, o_last, o_data},
               {1'b1, 2'd0, 1'b1, 32'h60});
    end
    drain();
  endtask

  // Model: a packet owner that persists until its last beat, and a queue of
  // accepted-but-not-retired beats (at most one deep).
  task automatic test_random(input int n);
    beat_t         q[$];
    beat_t         nb;
    logic          locked  = 1'b0;
    logic [IW-1:0] owner   = '0;
    logic          out_in  = 1'b0;
    logic [IW-1:0] out_src = '0;
    int unsigned   seq [W];
    int unsigned   rem [W];
    logic [IW-1:0] src;
    logic [W-1:0]  exp_rdy;
    logic          have, can, acc, exp_ack, retire;
    int unsigned   r;
    for (int k = 0; k < W; k++) begin
      seq[k] = 0;
      rem[k] = $urandom_range(1, 4);
    end
    for (int c = 0; c < n; c++) begin
      r   = $urandom_range(0, 5);
      gnt = (r < W) ? (4'b0001 << r) : 4'b0000;
      for (int k = 0; k < W; k++) begin
        vld[k]                   = ($urandom_range(0, 9) < 7);
        last[k]                  = (rem[k] == 1);
        data[k*DATA_W +: DATA_W] = {8'(k), 24'(seq[k])};
      end
      rdy = ($urandom_range(0, 3) != 0);
      #1;
      src = owner;
      if (!locked) begin
        for (int k = 0; k < W; k++) if (gnt[k]) src = 2'(k);
      end
      have    = locked || (gnt != 0);
      can     = (q.size() == 0) || rdy;
      exp_rdy = (can && have) ? (4'b0001 << src) : 4'b0000;
      acc     = (vld & exp_rdy) != 0;
      exp_ack = acc && last[src];
      retire  = (q.size() != 0) && rdy;
      checks++;
      if (o_rdy !== exp_rdy) begin
        errors++;
        $display("FAIL rand_rdy cycle %0d got %b want %b", c, o_rdy, exp_rdy);
      end
      checks++;
      if (o_ack !== exp_ack) begin
        errors++;
        $display("FAIL rand_ack cycle %0d got %b want %b", c, o_ack, exp_ack);
      end
      if (o_vld && rdy) begin
        checks++;
        if (out_in && (o_src !== out_src)) begin
          errors++;
          $display("FAIL rand_interleave cycle %0d got src %0d want %0d", c, o_src, out_src);
        end
        out_in  = !o_last;
        out_src = o_src;
      end
      nb = '{src: src, last: last[src], data: data[int'(src)*DATA_W +: DATA_W]};
      tick();
      if (retire) void'(q.pop_front());
      if (acc) begin
        q.push_back(nb);
        seq[src]++;
        rem[src]--;
        if (rem[src] == 0) rem[src] = $urandom_range(1, 4);
        locked = !nb.last;
        owner  = src;
      end
      checks++;
      if (o_vld !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rand_vld cycle %0d got %b want %b", c, o_vld, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if ({o_src, o_last, o_data} !== q[0]) begin
          errors++;
          $display("FAIL rand_beat cycle %0d got %h want %h", c, {o_src, o_last, o_data}, q[0]);
        end
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_lock();
    test_back_to_back();
    test_downstream_stall();
    test_source_stall();
    test_reset_mid_packet();
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
